// File: rtl/reg_writeback_if.sv
// reg_writeback_if: result handshakes from the ALU and load unit, plus the
// register-file write port and hazard/occupancy status of the writeback queue.
// slave = writeback queue side, master = producers / consumers around it.
interface reg_writeback_if #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            ld_valid;
  logic            ld_ready;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;
  logic            reg_write;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] rd_data;
  logic [31:0]     pending;
  logic [CW-1:0]   count;

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    output alu_ready, ld_ready, reg_write, rd_addr, rd_data, pending, count
  );

  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    input  alu_ready, ld_ready, reg_write, rd_addr, rd_data, pending, count
  );
endinterface

// File: rtl/reg_writeback.sv
// reg_writeback: in-order writeback queue feeding the register-file write port.
// Accepts at most one result per edge (load or ALU), drops writes to x0,
// retires the FIFO head every edge it is non-empty, and exports a mask of
// registers with a write still queued or being presented.
// Optional feature macro: WB_RR_ARB_EN selects round-robin arbitration between
// load and ALU; when undefined, loads always win over the ALU.
module reg_writeback #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  reg_writeback_if.slave  wb
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0]   count_r;
  logic [AW-1:0]   head_r;
  logic [AW-1:0]   tail_r;
  logic [DEPTH-1:0] vld_r;
  logic [4:0]      mem_rd_r   [DEPTH];
  logic [XLEN-1:0] mem_data_r [DEPTH];
  logic            reg_write_r;
  logic [4:0]      rd_addr_r;
  logic [XLEN-1:0] rd_data_r;

  logic            space_s;
  logic            ld_ready_s;
  logic            alu_ready_s;
  logic            ld_grant_s;
  logic            alu_grant_s;
  logic            push_s;
  logic            pop_s;
  logic [4:0]      push_rd_s;
  logic [XLEN-1:0] push_data_s;
  logic [31:0]     pending_s;

`ifdef WB_RR_ARB_EN
  logic            alu_fav_r;   // 0: load favoured, 1: ALU favoured
  logic            flip_s;
`endif

  function automatic logic [31:0] onehot32(input logic [4:0] idx);
    return 32'd1 << idx;
  endfunction

  // Readiness: conservative space check that deliberately ignores the same-edge pop.
  always_comb begin
    space_s = (count_r < CW'(DEPTH));
`ifdef WB_RR_ARB_EN
    ld_ready_s  = space_s && !(wb.alu_valid && alu_fav_r);
    alu_ready_s = space_s && !(wb.ld_valid && !alu_fav_r);
    flip_s      = space_s && wb.ld_valid && wb.alu_valid;
`else
    ld_ready_s  = space_s;
    alu_ready_s = space_s && !wb.ld_valid;
`endif
  end

  // Grant selection and push/pop decisions; x0 results handshake but are not queued.
  always_comb begin
    ld_grant_s  = wb.ld_valid && ld_ready_s;
    alu_grant_s = wb.alu_valid && alu_ready_s;
    if (ld_grant_s) begin
      push_rd_s   = wb.ld_rd;
      push_data_s = wb.ld_data;
    end else begin
      push_rd_s   = wb.alu_rd;
      push_data_s = wb.alu_data;
    end
    push_s = (ld_grant_s || alu_grant_s) && (push_rd_s != 5'd0);
    pop_s  = (count_r != {CW{1'b0}});
  end

  // Queue control, output stage and arbiter pointer; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r     <= {CW{1'b0}};
      head_r      <= {AW{1'b0}};
      tail_r      <= {AW{1'b0}};
      vld_r       <= {DEPTH{1'b0}};
      reg_write_r <= 1'b0;
      rd_addr_r   <= 5'd0;
      rd_data_r   <= {XLEN{1'b0}};
`ifdef WB_RR_ARB_EN
      alu_fav_r   <= 1'b0;
`endif
    end else begin
      count_r <= count_r + CW'(push_s) - CW'(pop_s);
      if (pop_s) begin
        head_r        <= head_r + AW'(1);
        vld_r[head_r] <= 1'b0;
        reg_write_r   <= 1'b1;
        rd_addr_r     <= mem_rd_r[head_r];
        rd_data_r     <= mem_data_r[head_r];
      end else begin
        reg_write_r   <= 1'b0;
      end
      // head and tail only coincide when empty (no pop) or full (no push)
      if (push_s) begin
        tail_r        <= tail_r + AW'(1);
        vld_r[tail_r] <= 1'b1;
      end
`ifdef WB_RR_ARB_EN
      if (flip_s) begin
        alu_fav_r <= !alu_fav_r;
      end
`endif
    end
  end

  // Entry storage; validity is tracked separately so the payload needs no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_rd_r[tail_r]   <= push_rd_s;
      mem_data_r[tail_r] <= push_data_s;
    end
  end

  // Pending mask: every queued destination plus the one currently presented.
  always_comb begin
    pending_s = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      pending_s = pending_s | (vld_r[i] ? onehot32(mem_rd_r[i]) : 32'd0);
    end
    pending_s    = pending_s | (reg_write_r ? onehot32(rd_addr_r) : 32'd0);
    pending_s[0] = 1'b0;
  end

  assign wb.ld_ready  = ld_ready_s;
  assign wb.alu_ready = alu_ready_s;
  assign wb.reg_write = reg_write_r;
  assign wb.rd_addr   = rd_addr_r;
  assign wb.rd_data   = rd_data_r;
  assign wb.pending   = pending_s;
  assign wb.count     = count_r;
endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed vector table, a few hand-written sequences and
// randomized traffic checked against a queue-based reference model.
module tb_reg_writeback;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

`ifdef WB_RR_ARB_EN
  localparam logic LDR_AV = 1'b0;  // ALU favoured after the one contested grant
`else
  localparam logic LDR_AV = 1'b1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_writeback_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();

  reg_writeback #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (bus)
  );

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t            q[$];
  logic            m_out_v;
  logic [4:0]      m_out_rd;
  logic [XLEN-1:0] m_out_data;
  logic            m_alu_fav;

  typedef struct {
    logic lv; logic [4:0] lr; logic [31:0] ld;
    logic av; logic [4:0] ar; logic [31:0] ad;
    logic [CW-1:0] e_cnt; logic e_rw; logic [4:0] e_rd; logic [31:0] e_data;
    logic [31:0] e_pend; logic e_ldr; logic e_alur;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                        input logic av, input logic [4:0] ar, input logic [31:0] ad);
    bus.ld_valid  = lv;
    bus.ld_rd     = lr;
    bus.ld_data   = ld;
    bus.alu_valid = av;
    bus.alu_rd    = ar;
    bus.alu_data  = ad;
  endtask

  function automatic vec_t mk(input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                              input logic av, input logic [4:0] ar, input logic [31:0] ad,
                              input logic [CW-1:0] c, input logic rw, input logic [4:0] rd,
                              input logic [31:0] dt, input logic [31:0] pd,
                              input logic ldr, input logic alur);
    vec_t v;
    v.lv = lv; v.lr = lr; v.ld = ld; v.av = av; v.ar = ar; v.ad = ad;
    v.e_cnt = c; v.e_rw = rw; v.e_rd = rd; v.e_data = dt; v.e_pend = pd;
    v.e_ldr = ldr; v.e_alur = alur;
    return v;
  endfunction

  // Reference model: readiness rules, pending mask and one clock of queue behaviour.
  function automatic logic mdl_space();
    return q.size() < DEPTH;
  endfunction

  function automatic logic mdl_ld_ready();
`ifdef WB_RR_ARB_EN
    return mdl_space() && !(bus.alu_valid && m_alu_fav);
`else
    return mdl_space();
`endif
  endfunction

  function automatic logic mdl_alu_ready();
`ifdef WB_RR_ARB_EN
    return mdl_space() && !(bus.ld_valid && !m_alu_fav);
`else
    return mdl_space() && !bus.ld_valid;
`endif
  endfunction

  function automatic logic [31:0] mdl_pending();
    logic [31:0] p;
    p = 32'd0;
    foreach (q[i]) p[q[i].rd] = 1'b1;
    if (m_out_v) p[m_out_rd] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  task automatic model_reset();
    q.delete();
    m_out_v    = 1'b0;
    m_out_rd   = 5'd0;
    m_out_data = 32'd0;
    m_alu_fav  = 1'b0;
  endtask

  task automatic model_step();
    logic lg, ag, both, sp;
    ent_t e;
    sp   = mdl_space();
    lg   = bus.ld_valid && mdl_ld_ready();
    ag   = bus.alu_valid && mdl_alu_ready();
    both = bus.ld_valid && bus.alu_valid;
    if (q.size() > 0) begin
      e = q.pop_front();
      m_out_v = 1'b1; m_out_rd = e.rd; m_out_data = e.data;
    end else begin
      m_out_v = 1'b0;
    end
    if (lg && bus.ld_rd != 5'd0) q.push_back({bus.ld_rd, bus.ld_data});
    else if (ag && bus.alu_rd != 5'd0) q.push_back({bus.alu_rd, bus.alu_data});
`ifdef WB_RR_ARB_EN
    if (both && sp) m_alu_fav = !m_alu_fav;
`else
    if (both && sp) m_alu_fav = m_alu_fav;
`endif
  endtask

  task automatic model_check(input string tag);
    check($sformatf("%s.count", tag), 64'(bus.count), 64'(q.size()));
    check($sformatf("%s.reg_write", tag), 64'(bus.reg_write), 64'(m_out_v));
    check($sformatf("%s.rd_addr", tag), 64'(bus.rd_addr), 64'(m_out_rd));
    check($sformatf("%s.rd_data", tag), 64'(bus.rd_data), 64'(m_out_data));
    check($sformatf("%s.pending", tag), 64'(bus.pending), 64'(mdl_pending()));
    check($sformatf("%s.ld_ready", tag), 64'(bus.ld_ready), 64'(mdl_ld_ready()));
    check($sformatf("%s.alu_ready", tag), 64'(bus.alu_ready), 64'(mdl_alu_ready()));
  endtask

  // Inputs already applied at the falling edge: settle, compare, advance model, next falling edge.
  task automatic step(input string tag);
    #1;
    model_check(tag);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    rst_n = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    // single write, contested sources, x0 drop, same-rd ordering
    tbl[0]  = mk(0,0,0,        1,5,32'h1234, 0,0,0,0,        0,         1,1);
    tbl[1]  = mk(0,0,0,        0,0,0,        1,0,0,0,        32'h20,    1,1);
    tbl[2]  = mk(0,0,0,        0,0,0,        0,1,5,32'h1234, 32'h20,    1,1);
    tbl[3]  = mk(0,0,0,        0,0,0,        0,0,5,32'h1234, 0,         1,1);
    tbl[4]  = mk(1,3,32'hAA,   1,4,32'hBB,   0,0,5,32'h1234, 0,         1,0);
    tbl[5]  = mk(0,0,0,        1,4,32'hBB,   1,0,5,32'h1234, 32'h08,    LDR_AV,1);
    tbl[6]  = mk(0,0,0,        0,0,0,        1,1,3,32'hAA,   32'h18,    1,1);
    tbl[7]  = mk(0,0,0,        0,0,0,        0,1,4,32'hBB,   32'h10,    1,1);
    tbl[8]  = mk(0,0,0,        0,0,0,        0,0,4,32'hBB,   0,         1,1);
    tbl[9]  = mk(0,0,0,        1,0,32'hFF,   0,0,4,32'hBB,   0,         LDR_AV,1);
    tbl[10] = mk(0,0,0,        0,0,0,        0,0,4,32'hBB,   0,         1,1);
    tbl[11] = mk(0,0,0,        1,7,32'h1,    0,0,4,32'hBB,   0,         LDR_AV,1);
    tbl[12] = mk(0,0,0,        1,7,32'h2,    1,0,4,32'hBB,   32'h80,    LDR_AV,1);
    tbl[13] = mk(0,0,0,        0,0,0,        1,1,7,32'h1,    32'h80,    1,1);
    tbl[14] = mk(0,0,0,        0,0,0,        0,1,7,32'h2,    32'h80,    1,1);
    tbl[15] = mk(0,0,0,        0,0,0,        0,0,7,32'h2,    0,         1,1);

    do_reset(2);
    for (int i = 0; i < 16; i++) begin
      set_in(tbl[i].lv, tbl[i].lr, tbl[i].ld, tbl[i].av, tbl[i].ar, tbl[i].ad);
      #1;
      check($sformatf("vec%0d.count", i), 64'(bus.count), 64'(tbl[i].e_cnt));
      check($sformatf("vec%0d.reg_write", i), 64'(bus.reg_write), 64'(tbl[i].e_rw));
      check($sformatf("vec%0d.rd_addr", i), 64'(bus.rd_addr), 64'(tbl[i].e_rd));
      check($sformatf("vec%0d.rd_data", i), 64'(bus.rd_data), 64'(tbl[i].e_data));
      check($sformatf("vec%0d.pending", i), 64'(bus.pending), 64'(tbl[i].e_pend));
      check($sformatf("vec%0d.ld_ready", i), 64'(bus.ld_ready), 64'(tbl[i].e_ldr));
      check($sformatf("vec%0d.alu_ready", i), 64'(bus.alu_ready), 64'(tbl[i].e_alur));
      @(negedge clk);
    end

    // flood from both sources: occupancy bounded, order checked by the model
    do_reset(1);
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1, 5'($urandom_range(1, 31)), $urandom);
      #1;
      check("flood.count_le_depth", 64'(bus.count <= CW'(DEPTH)), 64'd1);
      step("flood");
    end

    // reset in the middle of traffic: nothing queued may surface afterwards
    do_reset(1);
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 5'(9 + i), 32'hC0DE_0000 + 32'(i), 1'b0, 5'd0, 32'd0);
      step("midrst.fill");
    end
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    check("midrst.count", 64'(bus.count), 64'd0);
    check("midrst.reg_write", 64'(bus.reg_write), 64'd0);
    check("midrst.pending", 64'(bus.pending), 64'd0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("midrst.no_late_write", 64'(bus.reg_write), 64'd0);
      step("midrst.idle");
    end

    // randomized traffic with occasional resets
    do_reset(1);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        do_reset(1);
      end else begin
        set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
        step("rand");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
